// File: rtl/eth_stat_counters.sv
// Ethernet MAC statistics counter bank: per-event live counters with a shadow
// snapshot bank, sticky overflow flags and a 1-cycle registered read port.

module eth_stat_cnt_lane #(
    parameter int COUNTER_WIDTH = 32,
    parameter int SATURATE      = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_event,
    input  logic                     i_clear_all,
    input  logic                     i_snapshot,
    input  logic                     i_rd_clr,
    output logic [COUNTER_WIDTH-1:0] o_live,
    output logic [COUNTER_WIDTH-1:0] o_shadow,
    output logic                     o_ovf
);
    logic [COUNTER_WIDTH-1:0] r_live;
    logic [COUNTER_WIDTH-1:0] r_shadow;
    logic                     r_ovf;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_live   <= '0;
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else begin
            // Shadow takes the pre-update value, so it sees counts before any clear.
            if (i_snapshot)
                r_shadow <= r_live;
            if (i_clear_all) begin
                r_live <= '0;
                r_ovf  <= 1'b0;
            end else if (i_rd_clr) begin
                r_live <= {{(COUNTER_WIDTH-1){1'b0}}, i_event};
                r_ovf  <= 1'b0;
            end else if (i_event) begin
                if (r_live == {COUNTER_WIDTH{1'b1}}) begin
                    r_ovf  <= 1'b1;
                    r_live <= (SATURATE != 0) ? r_live : '0;
                end else begin
                    r_live <= r_live + 1'b1;
                end
            end
        end
    end

    assign o_live   = r_live;
    assign o_shadow = r_shadow;
    assign o_ovf    = r_ovf;
endmodule

module eth_stat_counters #(
    parameter int NUM_EVENTS    = 9,
    parameter int COUNTER_WIDTH = 32,
    parameter int SATURATE      = 1,
    parameter int ADDR_WIDTH    = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_EVENTS-1:0]    events,
    input  logic                     clear_all,
    input  logic                     snapshot,
    input  logic                     rd_req,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic                     rd_shadow,
    input  logic                     rd_clear,
    output logic                     rd_valid,
    output logic [COUNTER_WIDTH-1:0] rd_data,
    output logic                     rd_error,
    output logic [NUM_EVENTS-1:0]    overflow
);
    logic [NUM_EVENTS-1:0][COUNTER_WIDTH-1:0] w_live;
    logic [NUM_EVENTS-1:0][COUNTER_WIDTH-1:0] w_shadow;
    logic [NUM_EVENTS-1:0]                    w_rd_clr;
    logic [COUNTER_WIDTH-1:0]                 w_rd_val;
    logic                                     w_hit;

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_lane
        eth_stat_cnt_lane #(
            .COUNTER_WIDTH(COUNTER_WIDTH),
            .SATURATE     (SATURATE)
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .i_event    (events[g]),
            .i_clear_all(clear_all),
            .i_snapshot (snapshot),
            .i_rd_clr   (w_rd_clr[g]),
            .o_live     (w_live[g]),
            .o_shadow   (w_shadow[g]),
            .o_ovf      (overflow[g])
        );
    end

    // Address decode doubles as range check: no lane match means out of range.
    always_comb begin
        w_hit    = 1'b0;
        w_rd_val = '0;
        w_rd_clr = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (32'(rd_addr) == 32'(i)) begin
                w_hit       = 1'b1;
                w_rd_val    = rd_shadow ? w_shadow[i] : w_live[i];
                w_rd_clr[i] = rd_req & rd_clear & ~rd_shadow;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_error <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data  <= w_rd_val;
                rd_error <= ~w_hit;
            end
        end
    end
endmodule

// File: tb/tb_eth_stat_counters.sv
// Scoreboard bench: a saturating and a wrapping 8-bit instance share stimulus;
// read expectations are queued when issued and popped when rd_valid appears.

module tb_eth_stat_counters;
    localparam int NE = 9;
    localparam int CW = 8;
    localparam int AW = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, clear_all, snapshot, rd_req, rd_shadow, rd_clear;
    logic [NE-1:0] events;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_valid, rd_error;
    logic [CW-1:0] rd_data [2];
    logic [NE-1:0] overflow [2];

    eth_stat_counters #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .SATURATE(1), .ADDR_WIDTH(AW)) u_sat (
        .clock(clock), .reset(reset), .events(events), .clear_all(clear_all),
        .snapshot(snapshot), .rd_req(rd_req), .rd_addr(rd_addr), .rd_shadow(rd_shadow),
        .rd_clear(rd_clear), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
        .rd_error(rd_error[0]), .overflow(overflow[0]));

    eth_stat_counters #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .SATURATE(0), .ADDR_WIDTH(AW)) u_wrap (
        .clock(clock), .reset(reset), .events(events), .clear_all(clear_all),
        .snapshot(snapshot), .rd_req(rd_req), .rd_addr(rd_addr), .rd_shadow(rd_shadow),
        .rd_clear(rd_clear), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
        .rd_error(rd_error[1]), .overflow(overflow[1]));

    typedef struct packed {
        logic [CW-1:0] d0;
        logic [CW-1:0] d1;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] m_live [2][NE];
    logic [CW-1:0] m_shd  [2][NE];
    logic [NE-1:0] m_ovf  [2];
    logic [CW-1:0] held   [2];
    logic          held_err;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: update the reference model from the current inputs, then compare.
    task automatic step();
        exp_t e;
        logic exp_vld;
        exp_vld = 1'b0;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NE; i++) begin
                    m_live[k][i] = '0;
                    m_shd[k][i]  = '0;
                end
                m_ovf[k] = '0;
            end
        end else begin
            if (rd_req) begin
                e.err = (int'(rd_addr) >= NE);
                e.d0  = '0;
                e.d1  = '0;
                if (!e.err) begin
                    e.d0 = rd_shadow ? m_shd[0][rd_addr] : m_live[0][rd_addr];
                    e.d1 = rd_shadow ? m_shd[1][rd_addr] : m_live[1][rd_addr];
                end
                sb.push_back(e);
                exp_vld = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                if (snapshot)
                    for (int i = 0; i < NE; i++) m_shd[k][i] = m_live[k][i];
                if (clear_all) begin
                    for (int i = 0; i < NE; i++) m_live[k][i] = '0;
                    m_ovf[k] = '0;
                end else begin
                    for (int i = 0; i < NE; i++) begin
                        if (rd_req && rd_clear && !rd_shadow && int'(rd_addr) == i) begin
                            m_live[k][i] = {7'd0, events[i]};
                            m_ovf[k][i]  = 1'b0;
                        end else if (events[i]) begin
                            if (m_live[k][i] == 8'hFF) begin
                                m_ovf[k][i] = 1'b1;
                                if (k == 1) m_live[k][i] = 8'h00;
                            end else begin
                                m_live[k][i] = m_live[k][i] + 8'd1;
                            end
                        end
                    end
                end
            end
        end
        @(posedge clock);
        #1;
        if (reset) begin
            held[0] = '0;
            held[1] = '0;
            held_err = 1'b0;
        end else if (exp_vld && sb.size() > 0) begin
            e = sb.pop_front();
            held[0] = e.d0;
            held[1] = e.d1;
            held_err = e.err;
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd_valid[%0d]", k), 64'(rd_valid[k]), 64'(exp_vld));
            chk($sformatf("rd_data[%0d]", k), 64'(rd_data[k]), 64'(held[k]));
            chk($sformatf("rd_error[%0d]", k), 64'(rd_error[k]), 64'(held_err));
            chk($sformatf("overflow[%0d]", k), 64'(overflow[k]), 64'(m_ovf[k]));
        end
    endtask

    task automatic cyc(input logic [NE-1:0] ev, input logic ca, input logic sn,
                       input logic rq, input logic [AW-1:0] a, input logic sh, input logic rc);
        events = ev; clear_all = ca; snapshot = sn;
        rd_req = rq; rd_addr = a; rd_shadow = sh; rd_clear = rc;
        step();
    endtask

    task automatic ev_n(input logic [NE-1:0] ev, input int n);
        for (int i = 0; i < n; i++) cyc(ev, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic sh, input logic rc);
        cyc('0, 0, 0, 1, a, sh, rc);
    endtask

    initial begin
        reset = 1'b1;
        cyc('0, 0, 0, 1, '0, 0, 0);
        cyc('1, 0, 0, 1, 5'd3, 0, 0);
        reset = 1'b0;
        chk("reset_ovf", 64'(overflow[0]), 64'd0);

        // Basic count
        ev_n(9'h001, 5);
        rd(5'd0, 0, 0);
        chk("cnt5_data", 64'(rd_data[0]), 64'd5);
        chk("cnt5_err", 64'(rd_error[0]), 64'd0);

        // Saturate vs wrap
        ev_n(9'h006, 257);
        ev_n(9'h004, 43);
        rd(5'd2, 0, 0);
        chk("sat_255", 64'(rd_data[0]), 64'd255);
        chk("wrap_300", 64'(rd_data[1]), 64'd44);
        chk("sat_ovf2", 64'(overflow[0][2]), 64'd1);
        rd(5'd1, 0, 0);
        chk("wrap_257", 64'(rd_data[1]), 64'd1);
        chk("wrap_ovf1", 64'(overflow[1][1]), 64'd1);
        rd(5'd2, 0, 1);
        chk("clrrd_255", 64'(rd_data[0]), 64'd255);
        chk("clrrd_ovf2", 64'(overflow[0][2]), 64'd0);
        rd(5'd2, 0, 0);
        chk("after_clr", 64'(rd_data[0]), 64'd0);

        // Clear-on-read keeps a concurrent event
        ev_n(9'h008, 10);
        cyc(9'h008, 0, 0, 1, 5'd3, 0, 1);
        chk("clr3_data", 64'(rd_data[0]), 64'd10);
        rd(5'd3, 0, 0);
        chk("clr3_after", 64'(rd_data[0]), 64'd1);

        // Snapshot, clear_all precedence
        ev_n(9'h010, 7);
        cyc('0, 0, 1, 1, 5'd4, 1, 0);
        chk("snap_same_cyc", 64'(rd_data[0]), 64'd0);
        ev_n(9'h010, 3);
        rd(5'd4, 1, 0);
        chk("shadow7", 64'(rd_data[0]), 64'd7);
        rd(5'd4, 0, 0);
        chk("live10", 64'(rd_data[0]), 64'd10);
        cyc(9'h010, 1, 0, 1, 5'd4, 0, 1);
        chk("clrall_read", 64'(rd_data[0]), 64'd10);
        rd(5'd4, 0, 0);
        chk("clrall_live0", 64'(rd_data[0]), 64'd0);
        rd(5'd4, 1, 0);
        chk("clrall_shadow7", 64'(rd_data[0]), 64'd7);
        ev_n(9'h010, 6);
        cyc('0, 0, 1, 1, 5'd4, 0, 1);
        rd(5'd4, 1, 0);
        chk("snap_preclr", 64'(rd_data[0]), 64'd6);
        rd(5'd4, 1, 1);
        rd(5'd4, 0, 0);
        chk("shclr_ignored", 64'(rd_data[0]), 64'd0);

        // Out of range
        rd(5'd9, 0, 0);
        chk("oor9_err", 64'(rd_error[0]), 64'd1);
        chk("oor9_data", 64'(rd_data[0]), 64'd0);
        rd(5'd31, 0, 1);
        chk("oor31_err", 64'(rd_error[1]), 64'd1);
        ev_n('0, 3);

        // Reset mid-count
        for (int i = 0; i < 20; i++) cyc(NE'($urandom), 0, 0, 0, '0, 0, 0);
        reset = 1'b1;
        cyc('1, 0, 0, 1, '0, 0, 0);
        reset = 1'b0;
        for (int a = 0; a < NE; a++) begin
            rd(AW'(a), 0, 0);
            chk($sformatf("rst_live%0d", a), 64'(rd_data[0]), 64'd0);
        end
        chk("rst_ovf", 64'(overflow[0]), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            cyc(NE'($urandom), $urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                1'($urandom), AW'($urandom_range(0, 11)), 1'($urandom), $urandom_range(0, 7) == 0);
        end
        reset = 1'b0;
        ev_n('0, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/eth_stat_counters.md
ETH_STAT_COUNTERS -- requirements
Module: eth_stat_counters

Interface
REQ-001 The block SHALL expose parameter NUM_EVENTS, default 9, number of independent event counters (1..32).
REQ-002 The block SHALL expose parameter COUNTER_WIDTH, default 32, bits per counter (8..64).
REQ-003 The block SHALL expose parameter SATURATE, default 1; 1 = saturate at all-ones, 0 = wrap to zero.
REQ-004 The block SHALL expose parameter ADDR_WIDTH, default 5, read address width; 2^ADDR_WIDTH >= NUM_EVENTS.
REQ-005 The block SHALL use one clock and a synchronous active-high reset: `clock`, input, 1, all logic on rising edge.
REQ-006 `reset`, input, 1, synchronous, active-high.
REQ-007 `events`, input, NUM_EVENTS, bit i high for one cycle = one count on counter i (MAC status pulses).
REQ-008 `clear_all`, input, 1, zero all live counters and overflow flags.
REQ-009 `snapshot`, input, 1, copy all live counters into shadow bank.
REQ-010 `rd_req`, input, 1, read request, one per cycle.
REQ-011 `rd_addr`, input, ADDR_WIDTH, counter index.
REQ-012 `rd_shadow`, input, 1, 1 = read shadow bank, 0 = live bank.
REQ-013 `rd_clear`, input, 1, clear-on-read of the addressed live counter.
REQ-014 `rd_valid`, output, 1, one-cycle pulse, read data valid.
REQ-015 `rd_data`, output, COUNTER_WIDTH, read result.
REQ-016 `rd_error`, output, 1, qualifies rd_valid; address out of range.
REQ-017 `overflow`, output, NUM_EVENTS, sticky per-counter overflow/saturation flag.

Function
REQ-018 Counter i SHALL increment by 1 on every cycle events[i]=1; all bits count concurrently and independently.
REQ-019 SATURATE=1: counter at all-ones with event SHALL stay all-ones and set overflow[i].
REQ-020 SATURATE=0: counter at all-ones with event SHALL become 0 and set overflow[i].
REQ-021 overflow[i] SHALL remain set until reset, clear_all, or a clearing read of counter i.
REQ-022 Read latency SHALL be 1 cycle: rd_req at cycle N -> rd_valid=1 at N+1 with rd_data/rd_error valid.
REQ-023 rd_data SHALL return the addressed counter value registered at start of cycle N (before cycle N's increment).
REQ-024 rd_data and rd_error SHALL hold their last value while rd_valid=0.
REQ-025 rd_clear with rd_shadow=0 SHALL set live counter to events[addr] of cycle N (concurrent event not lost) and clear overflow[addr].
REQ-026 rd_clear SHALL be ignored when rd_shadow=1 or when rd_req=0.
REQ-027 rd_addr >= NUM_EVENTS SHALL give rd_valid=1, rd_error=1, rd_data=0, no state change.
REQ-028 snapshot SHALL load shadow[i] with live counter i value before cycle's update, all i in the same cycle.
REQ-029 Snapshot and shadow read in same cycle SHALL return the previous shadow value.
REQ-030 Snapshot and clearing read in same cycle SHALL capture the pre-clear value into shadow.
REQ-031 clear_all SHALL take precedence: all live counters 0, all overflow 0, concurrent events and rd_clear discarded; shadow bank unaffected.
REQ-032 Read issued in clear_all cycle SHALL return pre-clear value.
REQ-033 Counter arithmetic SHALL be unsigned COUNTER_WIDTH, no carry beyond MSB.

Reset
REQ-034 reset SHALL zero live counters, shadow bank, overflow, rd_valid, rd_data, rd_error in the next cycle; reset overrides all inputs.
REQ-035 rd_req asserted during reset SHALL produce no rd_valid pulse.

Verification
REQ-036 events[0] high 5 cycles, then rd_req addr 0 -> rd_valid next cycle, rd_data=5, rd_error=0.
REQ-037 COUNTER_WIDTH=8, SATURATE=1, 300 events on bit 2 -> read 255, overflow[2]=1; clearing read -> overflow[2]=0, next read 0.
REQ-038 COUNTER_WIDTH=8, SATURATE=0, 257 events on bit 1 -> read 1, overflow[1]=1.
REQ-039 Counter 3 = 10, rd_clear read with events[3]=1 same cycle -> rd_data=10, subsequent read 1.
REQ-040 Counter 4 = 7, snapshot, then 3 more events -> shadow read 7, live read 10; clear_all -> live 0, shadow still 7.
REQ-041 rd_addr=NUM_EVENTS -> rd_valid=1, rd_error=1, rd_data=0; reset mid-count -> all reads 0, overflow=0.
